flag_branch_unit: RTL
=====================

// Module: flag_branch_unit
// PURPOSE
//   Consumer side of the ALU status path in the single-cycle CPU.
//   - Latches NZCV status (zero from zero_detected, plus negative/carry/overflow) on flag-setting instructions.
//   - Evaluates LEGv8 branch conditions and drives take_branch to the PC-select mux.
//   - Flag register holds state across instructions; branch decision is combinational within the cycle.
// PARAMETERS
//   RESET_FLAGS   4'b0000   NZCV value loaded on reset, order {N,Z,C,V}
//   NV_IS_ALWAYS  1         1: cond 4'b1111 is always-taken (ARM AL alias); 0: never taken
// PORTS
//   clk            input   1  clock; all state updates on rising edge
//   reset          input   1  asynchronous, active-high reset
//   alu_negative   input   1  ALU result bit 63 for current instruction
//   alu_zero       input   1  zero_detected for current ALU result
//   alu_carry      input   1  ALU carry-out
//   alu_overflow   input   1  ALU signed overflow
//   set_flags      input   1  current instruction writes NZCV (ADDS/SUBS/ANDS)
//   cond_branch    input   1  current instruction is B.cond
//   cbz            input   1  current instruction is CBZ (ALU passes Rt through)
//   uncond_branch  input   1  current instruction is B/BL/BR
//   cond           input   4  B.cond condition field
//   flags          output  4  registered NZCV {N,Z,C,V}
//   flags_valid    output  1  1 once any flag write has occurred since reset
//   take_branch    output  1  1 = PC loads branch target this cycle
// BEHAVIOUR
//   Reset (async, immediate): flags = RESET_FLAGS; flags_valid = 0; take_branch = 0 while reset high.
//   Flag register: rising clk with set_flags=1 and reset=0 loads {alu_negative,alu_zero,alu_carry,alu_overflow}.
//     - Sets flags_valid=1 (sticky until reset).
//     - set_flags=0 holds flags.
//     - No other input alters flags.
//   Evaluated flags E: registered flags (see CONFIGURATION for same-cycle bypass).
//   Condition table (1 = taken):
//     0000 EQ  Z           0001 NE  !Z
//     0010 HS  C           0011 LO  !C
//     0100 MI  N           0101 PL  !N
//     0110 VS  V           0111 VC  !V
//     1000 HI  C&!Z        1001 LS  !C|Z
//     1010 GE  N==V        1011 LT  N!=V
//     1100 GT  !Z&(N==V)   1101 LE  Z|(N!=V)
//     1110 AL  1           1111 NV  NV_IS_ALWAYS
//   take_branch (combinational), priority when several strobes high:
//     - uncond_branch              -> 1
//     - else cbz                   -> alu_zero (live input, never the registered Z)
//     - else cond_branch           -> table(cond,E) & flags_valid
//     - else                       -> 0
//   Stale flags: B.cond with flags_valid=0 is never taken, including AL/NV.
//   CBZ and set_flags may coincide: CBZ still uses live alu_zero; flags load at the edge.
//   Latency: flags visible on flags output 1 cycle after set_flags edge; take_branch 0-cycle.
//   Reset asserted mid-cycle: flags and flags_valid clear immediately, independent of clk; take_branch drops to 0.
// CONFIGURATION
//   FLAG_FORWARD_EN defined:
//     - When set_flags & cond_branch are both high in the same cycle, E = incoming ALU flags.
//     - flags_valid is treated as 1 for that evaluation.
//   FLAG_FORWARD_EN undefined:
//     - E is always the registered flags (old value).
//     - B.cond in a set_flags cycle sees pre-update state.
//   Register-update behaviour is identical in both builds.
// TESTING
//   - Reset: assert reset mid-cycle -> flags=0000, flags_valid=0, take_branch=0 before next edge.
//   - SUBS 5-5 (N0 Z1 C1 V0) then B.EQ: next cycle flags=0110, take_branch=1. Same state: B.NE -> 0, B.GE -> 1, B.HI -> 0.
//   - Signed: flags N1 V0 -> B.LT=1, B.GE=0, B.LE=1. Flags N1 V1 Z0 -> B.GT=1.
//   - After reset, no flag write, B.AL (cond=1110) -> take_branch=0. After one SUBS -> take_branch=1.
//   - CBZ with alu_zero=1 while registered Z=0 -> take_branch=1. alu_zero=0 with Z=1 -> 0.
//     uncond_branch+cbz with alu_zero=0 -> 1.
//   - set_flags+cond_branch same cycle, old Z=0, new Z=1, cond=EQ:
//     -> 1 with FLAG_FORWARD_EN, 0 without; flags=x1xx after the edge in both builds.

Source files
------------

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: NZCV flag register and LEGv8 branch decision (optional `FLAG_FORWARD_EN same-cycle flag bypass)
module flag_branch_unit #(
  parameter logic [3:0] RESET_FLAGS  = 4'b0000,
  parameter logic       NV_IS_ALWAYS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_negative,
  input  logic       alu_zero,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       set_flags,
  input  logic       cond_branch,
  input  logic       cbz,
  input  logic       uncond_branch,
  input  logic [3:0] cond,
  output logic [3:0] flags,
  output logic       flags_valid,
  output logic       take_branch
);
  logic [3:0] flags_q, flags_d, alu_flags, e;
  logic       valid_q, valid_d, e_valid, cond_ok;
  assign alu_flags = {alu_negative, alu_zero, alu_carry, alu_overflow};
  // next-state for the flag register: load on flag-setting instructions, sticky valid
  always_comb begin
    flags_d = set_flags ? alu_flags : flags_q;
    valid_d = valid_q | set_flags;
  end
  // flag register with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= RESET_FLAGS;
      valid_q <= 1'b0;
    end else begin
      flags_q <= flags_d;
      valid_q <= valid_d;
    end
  end
  // flags seen by B.cond: bypass the incoming ALU flags only when forwarding is built in
  always_comb begin
`ifdef FLAG_FORWARD_EN
    e       = (set_flags & cond_branch) ? alu_flags : flags_q;
    e_valid = valid_q | (set_flags & cond_branch);
`else
    e       = flags_q;
    e_valid = valid_q;
`endif
  end
  // condition table over evaluated flags {N,Z,C,V}
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = e[2];
      4'b0001: cond_ok = ~e[2];
      4'b0010: cond_ok = e[1];
      4'b0011: cond_ok = ~e[1];
      4'b0100: cond_ok = e[3];
      4'b0101: cond_ok = ~e[3];
      4'b0110: cond_ok = e[0];
      4'b0111: cond_ok = ~e[0];
      4'b1000: cond_ok = e[1] & ~e[2];
      4'b1001: cond_ok = ~e[1] | e[2];
      4'b1010: cond_ok = e[3] ~^ e[0];
      4'b1011: cond_ok = e[3] ^ e[0];
      4'b1100: cond_ok = ~e[2] & (e[3] ~^ e[0]);
      4'b1101: cond_ok = e[2] | (e[3] ^ e[0]);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = NV_IS_ALWAYS;
    endcase
  end
  // branch priority: unconditional, then CBZ on live zero, then B.cond gated by valid flags
  always_comb begin
    take_branch = reset         ? 1'b0 :
                  uncond_branch ? 1'b1 :
                  cbz           ? alu_zero :
                  cond_branch   ? (cond_ok & e_valid) : 1'b0;
  end
  assign flags       = flags_q;
  assign flags_valid = valid_q;
endmodule
